mem_access_ctrl: RTL
====================

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 SHALL have parameter BITS_SIZE, default 32, data word width.
REQ-002 SHALL have parameter ADDR_BITS, default 10, word-address width to data memory.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 16, max cycles waiting for memory ack.
REQ-004 SHALL have port i_clk  in  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port i_reset  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port i_req  in  1  MEM stage holds a load/store.
REQ-007 SHALL have port i_write  in  1  1=store, 0=load.
REQ-008 SHALL have port i_size  in  2  access size: 00 word, 01 byte, 10 halfword, 11 illegal.
REQ-009 SHALL have port i_addr  in  BITS_SIZE  byte address.
REQ-010 SHALL have port i_wdata  in  BITS_SIZE  store data, datum in low bits.
REQ-011 SHALL have port o_stall  out  1  freeze pipeline.
REQ-012 SHALL have port o_done  out  1  one-cycle pulse: access complete.
REQ-013 SHALL have port o_rdata  out  BITS_SIZE  load word, addressed datum shifted to bit 0, for the writeback load filter.
REQ-014 SHALL have port o_err  out  1  one-cycle pulse: misaligned, illegal size or timeout.
REQ-015 SHALL have ports o_mem_en (1), o_mem_we (4), o_mem_addr (ADDR_BITS), o_mem_wdata (BITS_SIZE), all out: memory request.
REQ-016 SHALL have ports i_mem_ack (1) and i_mem_rdata (BITS_SIZE), both in: memory completion; data valid with ack.

Function
REQ-017 SHALL implement FSM IDLE, ACCESS, DONE, ERROR.
REQ-018 IDLE, i_req=1, legal and aligned: SHALL latch write/size/addr/wdata and go to ACCESS.
REQ-019 IDLE, i_req=1, illegal size or misaligned (half with addr[0]=1; word with addr[1:0]!=0): SHALL go to ERROR with no memory access.
REQ-020 ACCESS SHALL hold o_mem_en=1, o_mem_addr=addr[ADDR_BITS+1:2], and o_mem_we/o_mem_wdata stable until i_mem_ack.
REQ-021 Lane enables SHALL be: byte 0001<<addr[1:0]; half 0011<<{addr[1],0}; word 1111; all 0 for loads.
REQ-022 Store data SHALL be replicated: byte {4{wdata[7:0]}}; half {2{wdata[15:0]}}; word as-is.
REQ-023 On i_mem_ack in ACCESS, SHALL register o_rdata = i_mem_rdata >> (8*addr[1:0]) for loads (zero-fill from the top), hold the previous o_rdata for stores, and go to DONE.
REQ-024 SHALL count cycles in ACCESS; at TIMEOUT_CYCLES without ack, SHALL drop o_mem_en and go to ERROR.
REQ-025 DONE SHALL assert o_done for exactly one cycle, then go to IDLE.
REQ-026 ERROR SHALL assert o_err for exactly one cycle, then go to IDLE.
REQ-027 o_stall SHALL be combinational: 1 in ACCESS, or in IDLE with i_req=1; 0 in DONE and ERROR.
REQ-028 Minimum latency SHALL be: request cycle, ack cycle, done cycle. Back-to-back requests SHALL incur one IDLE cycle.
REQ-029 i_req changes during ACCESS SHALL be ignored. i_mem_ack outside ACCESS SHALL be ignored.
REQ-030 Ack arriving on the same cycle the timeout count is reached SHALL win: go to DONE.

Reset
REQ-031 Asserting i_reset (low) SHALL asynchronously force IDLE and clear the timeout counter.
REQ-032 During reset, outputs SHALL be: o_mem_en=0, o_mem_we=0000, o_done=0, o_err=0, o_rdata=0, o_mem_addr=0, o_mem_wdata=0.
REQ-033 Reset mid-ACCESS SHALL abandon the transaction with no o_done.

Structure
REQ-034 Size encodings, FSM state codes and the default TIMEOUT SHALL live in the shared package mips_mem_pkg; these size encodings are the same ones the writeback load filter uses.
REQ-035 Lane logic (we, wdata replication, rdata shift) SHALL be the combinational sub-module mem_lane_align.

Verification
REQ-036 Load: LW addr 0x10, ack after 2 cycles, rdata 0xDEADBEEF -> o_mem_addr=4, we=0000, o_rdata=0xDEADBEEF, o_done 1 cycle; stall high until done.
REQ-037 Byte store: SB addr 0x13, wdata 0x000000A5 -> we=1000, o_mem_wdata=0xA5A5A5A5.
REQ-038 Half load: LH addr 0x06, rdata 0x8001_1234 -> o_rdata=0x0000_8001.
REQ-039 Misaligned: LW addr 0x02 -> o_err pulse next cycle, o_mem_en never asserted.
REQ-040 Timeout: no ack -> o_err after 16 ACCESS cycles, o_mem_en low afterwards.
REQ-041 Reset mid-ACCESS -> o_mem_en low immediately, IDLE, no o_done.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// rtl/mips_mem_pkg.sv - shared access-size encodings, FSM states and defaults for the MEM stage
//
// Purpose: single source for the load/store size codes (also used by the
// writeback load filter), the access controller state codes and the
// default memory-ack timeout.
// Ports: none (package).
package mips_mem_pkg;

  // Access size codes as driven by the decoder and consumed by the load filter.
  typedef enum logic [1:0] {
    SIZE_WORD    = 2'b00,
    SIZE_BYTE    = 2'b01,
    SIZE_HALF    = 2'b10,
    SIZE_ILLEGAL = 2'b11
  } mem_size_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_DONE   = 2'b10,
    ST_ERROR  = 2'b11
  } mem_state_e;

  localparam int DEFAULT_TIMEOUT = 16;

  // Legal size with natural alignment for that size.
  function automatic logic access_legal(input mem_size_e size, input logic [1:0] addr_lo);
    logic ok;
    ok = 1'b0;
    case (size)
      SIZE_BYTE: ok = 1'b1;
      SIZE_HALF: ok = ~addr_lo[0];
      SIZE_WORD: ok = (addr_lo == 2'b00);
      default:   ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - byte-lane enables, store replication and load shift for a 32-bit data port
//
// Purpose: purely combinational lane steering between the core datum
// (always in the low bits) and the word-wide memory port.
// Ports:
//   i_write      1=store, 0=load (loads get no lane enables)
//   i_size       access size code (mem_size_e)
//   i_addr_lo    byte offset within the word
//   i_wdata      store datum, low bits
//   i_mem_rdata  raw word from memory
//   o_we         per-byte write enables
//   o_wdata      store data replicated across all lanes
//   o_rdata      memory word shifted so the addressed datum sits at bit 0
module mem_lane_align
  import mips_mem_pkg::*;
#(
  parameter int BITS_SIZE = 32
) (
  input  logic                 i_write,
  input  logic [1:0]           i_size,
  input  logic [1:0]           i_addr_lo,
  input  logic [BITS_SIZE-1:0] i_wdata,
  input  logic [BITS_SIZE-1:0] i_mem_rdata,
  output logic [3:0]           o_we,
  output logic [BITS_SIZE-1:0] o_wdata,
  output logic [BITS_SIZE-1:0] o_rdata
);

  always_comb begin
    o_we    = 4'b0000;
    o_wdata = i_wdata;
    case (mem_size_e'(i_size))
      SIZE_BYTE: begin
        o_we    = 4'b0001 << i_addr_lo;
        o_wdata = {(BITS_SIZE/8){i_wdata[7:0]}};
      end
      SIZE_HALF: begin
        o_we    = 4'b0011 << {i_addr_lo[1], 1'b0};
        o_wdata = {(BITS_SIZE/16){i_wdata[15:0]}};
      end
      SIZE_WORD: begin
        o_we    = 4'b1111;
        o_wdata = i_wdata;
      end
      default: begin
        o_we    = 4'b0000;
        o_wdata = i_wdata;
      end
    endcase
    if (!i_write) begin
      o_we = 4'b0000;
    end
  end

  // Logical shift: upper bytes zero-fill; sign/zero extension is the load filter's job.
  assign o_rdata = i_mem_rdata >> {i_addr_lo, 3'b000};

endmodule

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - MEM-stage load/store controller with stall, lane steering and ack timeout
//
// Purpose: accepts one load/store from the MEM stage, checks size/alignment,
// drives a word-addressed memory port until ack or timeout, and reports
// completion (o_done) or error (o_err) as one-cycle pulses.
// Ports:
//   i_clk, i_reset       clock, asynchronous active-low reset
//   i_req/i_write/i_size/i_addr/i_wdata   request from the pipeline
//   o_stall              combinational pipeline freeze
//   o_done, o_err        one-cycle completion / error pulses
//   o_rdata              registered load word, datum at bit 0
//   o_mem_en/we/addr/wdata  memory request
//   i_mem_ack, i_mem_rdata  memory completion, data valid with ack
module mem_access_ctrl
  import mips_mem_pkg::*;
#(
  parameter int BITS_SIZE      = 32,
  parameter int ADDR_BITS      = 10,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_req,
  input  logic                 i_write,
  input  logic [1:0]           i_size,
  input  logic [BITS_SIZE-1:0] i_addr,
  input  logic [BITS_SIZE-1:0] i_wdata,
  output logic                 o_stall,
  output logic                 o_done,
  output logic [BITS_SIZE-1:0] o_rdata,
  output logic                 o_err,
  output logic                 o_mem_en,
  output logic [3:0]           o_mem_we,
  output logic [ADDR_BITS-1:0] o_mem_addr,
  output logic [BITS_SIZE-1:0] o_mem_wdata,
  input  logic                 i_mem_ack,
  input  logic [BITS_SIZE-1:0] i_mem_rdata
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  mem_state_e             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   write_q, write_d;
  logic [1:0]             size_q, size_d;
  logic [ADDR_BITS+1:0]   addr_q, addr_d;
  logic [BITS_SIZE-1:0]   wdata_q, wdata_d;
  logic [BITS_SIZE-1:0]   rdata_q, rdata_d;

  logic [3:0]             lane_we;
  logic [BITS_SIZE-1:0]   lane_wdata;
  logic [BITS_SIZE-1:0]   lane_rdata;
  logic                   req_legal;

  // Address bits above the memory window do not select anything.
  logic unused_addr_hi;
  assign unused_addr_hi = ^i_addr[BITS_SIZE-1:ADDR_BITS+2];

  assign req_legal = access_legal(mem_size_e'(i_size), i_addr[1:0]);

  mem_lane_align #(
    .BITS_SIZE(BITS_SIZE)
  ) u_lane (
    .i_write    (write_q),
    .i_size     (size_q),
    .i_addr_lo  (addr_q[1:0]),
    .i_wdata    (wdata_q),
    .i_mem_rdata(i_mem_rdata),
    .o_we       (lane_we),
    .o_wdata    (lane_wdata),
    .o_rdata    (lane_rdata)
  );

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      write_q <= 1'b0;
      size_q  <= 2'b00;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      write_q <= write_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    write_d = write_q;
    size_d  = size_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (i_req) begin
          if (req_legal) begin
            write_d = i_write;
            size_d  = i_size;
            addr_d  = i_addr[ADDR_BITS+1:0];
            wdata_d = i_wdata;
            state_d = ST_ACCESS;
          end else begin
            state_d = ST_ERROR;
          end
        end
      end
      ST_ACCESS: begin
        // Ack is checked first so it wins over a timeout on the same cycle.
        if (i_mem_ack) begin
          if (!write_q) begin
            rdata_d = lane_rdata;
          end
          state_d = ST_DONE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_ERROR;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      ST_ERROR: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Memory strobes derive from the state register so an async reset drops them at once.
  assign o_mem_en    = (state_q == ST_ACCESS);
  assign o_mem_we    = o_mem_en ? lane_we : 4'b0000;
  assign o_mem_addr  = addr_q[ADDR_BITS+1:2];
  assign o_mem_wdata = lane_wdata;

  assign o_done  = (state_q == ST_DONE);
  assign o_err   = (state_q == ST_ERROR);
  assign o_rdata = rdata_q;
  assign o_stall = (state_q == ST_ACCESS) || ((state_q == ST_IDLE) && i_req);

endmodule
